// File: rtl/tank_ctrl.sv
// tank_ctrl: player tank with rotation, fixed-point movement, arena clamp,
// edge-triggered fire with cooldown, and a dead/respawn state machine.
module tank_ctrl #(
    parameter int X_START   = 320,
    parameter int Y_START   = 240,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 479,
    parameter int TANK_SIZE = 10,
    parameter int STEP      = 1,
    parameter logic [7:0] KEY_LEFT  = 8'h04,
    parameter logic [7:0] KEY_RIGHT = 8'h07,
    parameter logic [7:0] KEY_FWD   = 8'h1A,
    parameter logic [7:0] KEY_BACK  = 8'h16,
    parameter logic [7:0] KEY_FIRE  = 8'h2C,
    parameter int COOLDOWN  = 30,
    parameter int RESPAWN   = 120
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [31:0] keycode,
    input  logic        hit,
    input  logic [7:0]  sin,
    input  logic [7:0]  cos,
    output logic [9:0]  TankX,
    output logic [9:0]  TankY,
    output logic [9:0]  TankS,
    output logic [5:0]  Angle,
    output logic        ShootBullet,
    output logic        Alive
);
    localparam int CW = $clog2(COOLDOWN + 2);
    localparam int RW = $clog2(RESPAWN + 1);
    localparam int X_HI = X_MAX - TANK_SIZE + 1;
    localparam int Y_HI = Y_MAX - TANK_SIZE + 1;
    localparam logic [16:0] XS = 17'(X_START * 128);
    localparam logic [16:0] YS = 17'(Y_START * 128);
    localparam logic signed [17:0] STEP_S = 18'(STEP);

    typedef enum logic {ALIVE, DEAD} state_t;

    state_t state, state_n;
    logic [16:0] px, py, px_n, py_n;
    logic [5:0] ang_n;
    logic [CW-1:0] cd, cd_n;
    logic [RW-1:0] rc, rc_n;
    logic prev_fire, shoot_n;
    logic left, right, fwd, back, fire, fwd_only, back_only, l_only, r_only;
    logic signed [17:0] dx, dy, nx, ny;

    function automatic logic pressed(input logic [31:0] kc, input logic [7:0] k);
        return kc[7:0] == k || kc[15:8] == k || kc[23:16] == k || kc[31:24] == k;
    endfunction

    // Negative sums mean the tank crossed pixel 0; treat them as below the minimum.
    function automatic logic [16:0] clamp(input logic signed [17:0] v, input int lo, input int hi);
        logic signed [17:0] i;
        i = v >>> 7;
        return (v < 0 || i < lo) ? 17'(lo * 128) : (i > hi) ? 17'(hi * 128) : v[16:0];
    endfunction

    assign left      = pressed(keycode, KEY_LEFT);
    assign right     = pressed(keycode, KEY_RIGHT);
    assign fwd       = pressed(keycode, KEY_FWD);
    assign back      = pressed(keycode, KEY_BACK);
    assign fire      = pressed(keycode, KEY_FIRE);
    assign fwd_only  = fwd & ~back;
    assign back_only = back & ~fwd;
    assign l_only    = left & ~right;
    assign r_only    = right & ~left;
    assign dx        = 18'(signed'(cos)) * STEP_S;
    assign dy        = 18'(signed'(sin)) * STEP_S;
    assign nx        = signed'({1'b0, px}) + (fwd_only ? dx : back_only ? -dx : 18'sd0);
    assign ny        = signed'({1'b0, py}) + (fwd_only ? -dy : back_only ? dy : 18'sd0);

    always_comb begin
        state_n = state;
        px_n    = px;
        py_n    = py;
        ang_n   = Angle;
        cd_n    = (cd == '0) ? '0 : cd - 1'b1;
        rc_n    = rc;
        shoot_n = 1'b0;
        if (state == ALIVE) begin
            if (hit) begin
                state_n = DEAD;
                rc_n    = RW'(RESPAWN - 1);
            end else begin
                px_n  = clamp(nx, X_MIN, X_HI);
                py_n  = clamp(ny, Y_MIN, Y_HI);
                ang_n = Angle + 6'(l_only) - 6'(r_only);
                if (fire && !prev_fire && cd == '0) begin
                    shoot_n = 1'b1;
                    cd_n    = CW'(COOLDOWN);
                end
            end
        end else if (rc == '0) begin
            state_n = ALIVE;
            px_n    = XS;
            py_n    = YS;
            ang_n   = '0;
            cd_n    = '0;
        end else begin
            rc_n = rc - 1'b1;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state       <= ALIVE;
            px          <= XS;
            py          <= YS;
            Angle       <= '0;
            cd          <= '0;
            rc          <= '0;
            prev_fire   <= 1'b0;
            ShootBullet <= 1'b0;
        end else begin
            state       <= state_n;
            px          <= px_n;
            py          <= py_n;
            Angle       <= ang_n;
            cd          <= cd_n;
            rc          <= rc_n;
            prev_fire   <= fire;
            ShootBullet <= shoot_n;
        end
    end

    assign TankX = px[16:7];
    assign TankY = py[16:7];
    assign TankS = 10'(TANK_SIZE);
    assign Alive = (state == ALIVE);
endmodule

// File: tb/tb_tank_ctrl.sv
// tb_tank_ctrl: directed scenarios plus randomized play checked every frame
// against an integer reference model of the tank.
module tb_tank_ctrl;
    localparam int X_START = 320, Y_START = 240, TANK_SIZE = 10, STEP = 1;
    localparam int X_HI = 639 - TANK_SIZE + 1, Y_HI = 479 - TANK_SIZE + 1;
    localparam int COOLDOWN = 30, RESPAWN = 120;
    localparam logic [7:0] K_L = 8'h04, K_R = 8'h07, K_F = 8'h1A, K_B = 8'h16, K_S = 8'h2C;

    logic frame_clk = 0, Reset = 1, hit = 0;
    logic [31:0] keycode = '0;
    logic [7:0] sin = '0, cos = '0;
    logic [9:0] TankX, TankY, TankS;
    logic [5:0] Angle;
    logic ShootBullet, Alive;

    tank_ctrl dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .hit(hit),
        .sin(sin), .cos(cos), .TankX(TankX), .TankY(TankY), .TankS(TankS),
        .Angle(Angle), .ShootBullet(ShootBullet), .Alive(Alive)
    );

    always #5 frame_clk = ~frame_clk;

    int checks = 0, failures = 0;
    int mx, my, ang_m, alive_m, shoot_m, prev_m, dead_cnt, last_shot, edge_n = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit has_key(input logic [31:0] kc, input logic [7:0] k);
        for (int i = 0; i < 4; i++) if (kc[8*i +: 8] == k) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] kc(input bit f, input bit b, input bit l, input bit r, input bit s);
        logic [31:0] v;
        int n;
        v = '0;
        n = 0;
        if (f) begin v[8*n +: 8] = K_F; n++; end
        if (b) begin v[8*n +: 8] = K_B; n++; end
        if (l) begin v[8*n +: 8] = K_L; n++; end
        if (r) begin v[8*n +: 8] = K_R; n++; end
        if (s && n < 4) v[8*n +: 8] = K_S;
        return v;
    endfunction

    function automatic int clampf(input int v, input int lo, input int hi);
        if (v < 0 || v / 128 < lo) return lo * 128;
        if (v / 128 > hi) return hi * 128;
        return v;
    endfunction

    // One frame of tank behaviour in plain integer terms (positions in 1/128 px).
    task automatic model_step();
        int dir, l, r;
        bit f, b, s;
        edge_n++;
        if (Reset) begin
            mx = X_START * 128; my = Y_START * 128; ang_m = 0; alive_m = 1;
            shoot_m = 0; prev_m = 0; dead_cnt = 0; last_shot = -100000;
            return;
        end
        shoot_m = 0;
        s = has_key(keycode, K_S);
        if (!alive_m) begin
            dead_cnt++;
            if (dead_cnt == RESPAWN) begin
                alive_m = 1; mx = X_START * 128; my = Y_START * 128; ang_m = 0;
                last_shot = -100000;
            end
        end else if (hit) begin
            alive_m = 0;
            dead_cnt = 0;
        end else begin
            f = has_key(keycode, K_F);
            b = has_key(keycode, K_B);
            dir = (f && !b) ? 1 : (b && !f) ? -1 : 0;
            mx = clampf(mx + dir * int'($signed(cos)) * STEP, 0, X_HI);
            my = clampf(my - dir * int'($signed(sin)) * STEP, 0, Y_HI);
            l = has_key(keycode, K_L) ? 1 : 0;
            r = has_key(keycode, K_R) ? 1 : 0;
            ang_m = (ang_m + l - r + 64) % 64;
            if (s && !prev_m && edge_n - last_shot > COOLDOWN) begin
                shoot_m = 1;
                last_shot = edge_n;
            end
        end
        prev_m = s;
    endtask

    always @(posedge frame_clk) begin
        model_step();
        #1;
        chk("TankX", TankX, mx / 128);
        chk("TankY", TankY, my / 128);
        chk("TankS", TankS, TANK_SIZE);
        chk("Angle", Angle, ang_m);
        chk("ShootBullet", ShootBullet, shoot_m);
        chk("Alive", Alive, alive_m);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    initial begin
        logic [7:0] keys [5];
        logic [31:0] v;
        int r;
        keys = '{K_L, K_R, K_F, K_B, K_S};
        cyc(2);
        chk("rst_x", TankX, 320); chk("rst_y", TankY, 240); chk("rst_ang", Angle, 0);
        chk("rst_alive", Alive, 1); chk("rst_shoot", ShootBullet, 0);
        Reset = 0;
        keycode = kc(1, 0, 0, 0, 0); cos = 8'd127; sin = 8'd0;
        cyc(10);
        chk("fwd10_x", TankX, 329); chk("fwd10_model_x", mx / 128, 329);
        chk("fwd10_y", TankY, 240); chk("fwd10_ang", Angle, 0);
        keycode = kc(0, 0, 1, 0, 0); cyc(65);
        chk("left65_ang", Angle, 1); chk("left65_model_ang", ang_m, 1);
        keycode = kc(0, 0, 1, 1, 0); cyc(5);
        chk("lr_ang", Angle, 1);
        keycode = kc(0, 1, 0, 0, 0); cyc(340);
        chk("back_clamp_x", TankX, 0);
        keycode = kc(1, 0, 0, 0, 0); cyc(2);
        chk("x_is_1", TankX, 1);
        cos = 8'(-127); cyc(5);
        chk("low_clamp_x", TankX, 0); chk("low_clamp_model_x", mx / 128, 0);
        cos = 8'd127; cyc(700);
        chk("high_clamp_x", TankX, 630);
        cos = 8'd0; sin = 8'd127; cyc(300);
        chk("low_clamp_y", TankY, 0);
        keycode = kc(0, 1, 0, 0, 0); cyc(500);
        chk("high_clamp_y", TankY, 470);
        keycode = '0; sin = 8'd0; cyc(2);
        for (int f = 0; f < 32; f++) begin
            keycode = (f < 5 || (f >= 10 && f < 13) || f == 31) ? kc(0, 0, 0, 0, 1) : '0;
            cyc(1);
            chk($sformatf("fire_f%0d", f), ShootBullet, (f == 0 || f == 31) ? 1 : 0);
        end
        keycode = '0; cyc(1);
        hit = 1; cyc(1);
        chk("hit_alive", Alive, 0);
        hit = 0; keycode = kc(1, 0, 1, 0, 1); cos = 8'd127;
        cyc(RESPAWN - 1);
        chk("dead_alive", Alive, 0); chk("dead_x", TankX, 630); chk("dead_ang", Angle, 1);
        cyc(1);
        keycode = '0;
        chk("respawn_alive", Alive, 1); chk("respawn_x", TankX, 320);
        chk("respawn_y", TankY, 240); chk("respawn_ang", Angle, 0);
        cyc(2);
        keycode = kc(0, 0, 0, 0, 1); hit = 1; cyc(1);
        chk("hitfire_shoot", ShootBullet, 0); chk("hitfire_alive", Alive, 0);
        hit = 0; keycode = '0; cyc(30);
        Reset = 1; cyc(1);
        chk("rst_dead_alive", Alive, 1); chk("rst_dead_x", TankX, 320);
        chk("rst_dead_y", TankY, 240); chk("rst_dead_ang", Angle, 0);
        Reset = 0;
        for (int n = 0; n < 4000; n++) begin
            v = '0;
            for (int s = 0; s < 4; s++) begin
                r = int'($urandom_range(0, 9));
                v[8*s +: 8] = (r < 4) ? 8'h00 : (r < 9) ? keys[r-4] : 8'($urandom);
            end
            keycode = v;
            cos = 8'(int'($urandom_range(0, 254)) - 127);
            sin = 8'(int'($urandom_range(0, 254)) - 127);
            hit = ($urandom_range(0, 149) == 0);
            Reset = ($urandom_range(0, 599) == 0);
            cyc(1);
        end
        Reset = 0; hit = 0; keycode = '0;
        cyc(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
